// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, index-width helper and the cleared response flags.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic err;
    logic load;
  } rsp_flags_t;

  localparam rsp_flags_t RSP_ZERO = '{
    valid: 1'b0,
    err:   1'b0,
    load:  1'b0
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM, registered read, no reset.
// A read only updates rdata_o when en_i is high and we_i is low.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int IW     = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**IW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable
// wait states, registered response held until the initiator takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  localparam int IW = clog2(DEPTH_WORDS);
  localparam int CW = 4;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  rsp_flags_t        rsp_q, rsp_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              addr_err;
  logic [IW-1:0]     idx;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  // Any bit above the word index makes the address out of range.
  assign addr_err = (addr_q[1:0] != 2'b00)
                 || ((addr_q >> (IW + 2)) != '0);
  assign idx      = addr_q[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ram_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && ready_q) begin
          wr_d    = REQ_WRITE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          cnt_d   = CW'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ram_en  = !addr_err;
          state_d = RESP;
          rsp_d   = '{
            valid: 1'b1,
            err:   addr_err,
            load:  !wr_q && !addr_err
          };
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_d   = RSP_ZERO;
          state_d = IDLE;
        end
      end
      default: begin
        rsp_d   = RSP_ZERO;
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rsp_q   <= RSP_ZERO;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_array (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (wr_q),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_q.valid;
  assign RSP_ERR   = rsp_q.err;
  // Read data is gated by a registered flag so stores and errors give 0.
  assign RSP_RDATA = rsp_q.load ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder (LATENCY=2 and LATENCY=0).
// Expected data comes from a word-indexed associative-array memory model.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int tests;
  int fails;

  logic [31:0] mem_m [int];

  dmem_responder #(.LATENCY(2)) u_dut_a (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .REQ_VALID (a_req_valid),
    .REQ_READY (a_req_ready),
    .REQ_WRITE (a_req_write),
    .REQ_ADDR  (a_req_addr),
    .REQ_WDATA (a_req_wdata),
    .RSP_VALID (a_rsp_valid),
    .RSP_READY (a_rsp_ready),
    .RSP_RDATA (a_rsp_rdata),
    .RSP_ERR   (a_rsp_err)
  );

  dmem_responder #(.LATENCY(0)) u_dut_b (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .REQ_VALID (b_req_valid),
    .REQ_READY (b_req_ready),
    .REQ_WRITE (b_req_write),
    .REQ_ADDR  (b_req_addr),
    .REQ_WDATA (b_req_wdata),
    .RSP_VALID (b_rsp_valid),
    .RSP_READY (b_rsp_ready),
    .RSP_RDATA (b_rsp_rdata),
    .RSP_ERR   (b_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 12) != 0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // One transaction on the LATENCY=2 instance, response held for `hold` cycles.
  task automatic txn(input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    int n;
    bit e;
    bit known;
    logic [31:0] exp_d;
    logic [31:0] d0;
    logic e0;
    n = 0;
    while (a_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", a_req_ready, 1);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr  = a;
    a_req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_write = $urandom_range(0, 1);
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    chk("req_ready_drop", a_req_ready, 0);
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, 3);
    e = is_err(a);
    known = 1'b1;
    exp_d = '0;
    if (!w && !e) begin
      if (mem_m.exists(widx(a))) exp_d = mem_m[widx(a)];
      else known = 1'b0;
    end
    chk("rsp_err", a_rsp_err, e);
    if (known) chk("rsp_rdata", a_rsp_rdata, exp_d);
    d0 = a_rsp_rdata;
    e0 = a_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", a_rsp_valid, 1);
      chk("bp_rdata", a_rsp_rdata, d0);
      chk("bp_err", a_rsp_err, e0);
      chk("bp_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("hs_valid_clr", a_rsp_valid, 0);
    chk("hs_rdata_clr", a_rsp_rdata, 0);
    chk("hs_err_clr", a_rsp_err, 0);
    chk("hs_req_ready", a_req_ready, 1);
    if (w && !e) mem_m[widx(a)] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    case ($urandom_range(0, 9))
      0: a = a | 32'($urandom_range(1, 3));
      1: a = a | (32'h1000 << $urandom_range(0, 19));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    int q[$];
    bit acc;
    bit prev_acc;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    a_req_addr = '0;    a_req_wdata = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0;
    b_req_addr = '0;    b_req_wdata = '0;
    b_rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", a_req_ready, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_rsp_rdata", a_rsp_rdata, 0);
      chk("rst_rsp_err", a_rsp_err, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready_pre", a_req_ready, 0);
    @(negedge clk);
    chk("rel_req_ready", a_req_ready, 1);
    chk("rel_rsp_valid", a_rsp_valid, 0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b1, 32'h13, 32'h0BADF00D, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b0, 32'h1000, 32'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 5);

    // Reset while a store sits in WAIT: the store must be dropped.
    txn(1'b1, 32'h20, 32'hAAAA5555, 0);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_rsp_valid, 0);
    chk("mid_rst_ready", a_req_ready, 0);
    chk("mid_rst_rdata", a_rsp_rdata, 0);
    chk("mid_rst_err", a_rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom,
          $urandom_range(0, 3));
    end

    // LATENCY=0 instance: valid held high, ready always high.
    b_req_valid = 1'b1;
    b_req_write = 1'b1;
    b_req_addr  = 32'h40;
    b_req_wdata = 32'hCAFEF00D;
    b_rsp_ready = 1'b1;
    prev_acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      acc = b_req_ready;
      @(posedge clk);
      @(negedge clk);
      if (prev_acc) begin
        chk("lat0_rsp_valid", b_rsp_valid, 1);
        chk("lat0_rsp_err", b_rsp_err, 0);
      end
      if (acc) q.push_back(c);
      prev_acc = acc;
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    if (prev_acc) chk("lat0_rsp_valid_last", b_rsp_valid, 1);
    chk("lat0_accept_count", q.size(), 4);
    if (q.size() > 0) chk("lat0_first_accept", q[0], 0);
    for (int i = 1; i < q.size(); i++) begin
      chk("lat0_spacing", q[i] - q[i-1], 3);
    end
    @(negedge clk);
    @(negedge clk);
    chk("lat0_idle_ready", b_req_ready, 1);
    chk("lat0_idle_valid", b_rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and performs the word access after a programmable number of wait states.
- It returns a response (read data or store acknowledge, plus an error flag) over a second valid/ready handshake.
- It replaces the zero-latency data memory, so the pipeline can be exercised against realistic memory latency and back-pressure.

Parameters:
- ADDR_W, 32, request byte-address width.
- DATA_W, 32, data word width.
- DEPTH_WORDS, 1024, number of words in the storage array; power of two.
- LATENCY, 2, wait-state cycles inserted before the access; legal range 0..15.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  responder can accept a request.
- REQ_WRITE  input  1  1 = store, 0 = load.
- REQ_ADDR  input  ADDR_W  byte address.
- REQ_WDATA  input  DATA_W  store data.
- RSP_VALID  output  1  response present.
- RSP_READY  input  1  initiator accepts the response.
- RSP_RDATA  output  DATA_W  load data; 0 for stores and for errors.
- RSP_ERR  output  1  misaligned or out-of-range request.

Behaviour:
- Reset and clocking:
  - One clock, CLK. RESET_N is asynchronous and active-low.
  - While RESET_N = 0: state = IDLE, REQ_READY = 0, RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0, wait counter = 0.
  - The storage array is not reset; its contents are undefined until written.
- States: IDLE, WAIT, RESP. All outputs come from registers; none depends combinationally on an input.
- IDLE:
  - REQ_READY = 1 from the first clock edge after RESET_N deasserts.
  - A request is accepted at edge k when REQ_VALID & REQ_READY.
  - On acceptance, REQ_WRITE, REQ_ADDR and REQ_WDATA are captured into internal registers.
  - Next state is WAIT with counter = LATENCY. REQ_READY drops to 0 after edge k.
- WAIT:
  - The counter decrements by 1 each edge.
  - At the edge where the counter equals 0, the access is performed and the state moves to RESP.
  - With LATENCY = 0, WAIT lasts exactly one cycle.
  - RSP_VALID therefore rises at edge k+LATENCY+1.
- Access rules:
  - Word index = addr[log2(DEPTH_WORDS)+1 : 2].
  - Error when addr[1:0] != 0, or when any address bit above the index is nonzero. On error: RSP_ERR = 1, RSP_RDATA = 0, and no store commits.
  - Store: the array word is written at the access edge; RSP_RDATA = 0.
  - Load: RSP_RDATA = array word at the access edge.
- RESP:
  - RSP_VALID, RSP_RDATA and RSP_ERR are held stable until RSP_VALID & RSP_READY.
  - At the handshake edge: RSP_VALID = 0, RSP_ERR = 0, RSP_RDATA = 0, state = IDLE, and REQ_READY = 1 after that edge.
  - Back-pressure is unlimited; responses are never dropped.
- Throughput: one outstanding request. Minimum spacing between acceptances is LATENCY+3 cycles (WAIT, RESP, IDLE).
- REQ_VALID while REQ_READY = 0 is ignored. The initiator must hold the request stable until it is accepted; the responder does not check this.
- A REQ_VALID held asserted across a response is accepted again only in the following IDLE cycle.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. A store that has not yet reached its access edge is dropped; committed stores persist.
- Read-after-write to the same address returns the newly stored value, since there is a single outstanding access.

Decomposition:
- Shared package dmem_pkg:
  - state encoding enum (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - index-width function clog2(DEPTH_WORDS);
  - constant RSP_ZERO.
- One sub-module, dmem_array: single-port synchronous word RAM with write enable, registered read, and no reset. It is instantiated once; the FSM and address checking stay in dmem_responder.

Test Plan:
- Reset, LATENCY=2: hold RESET_N=0 for 3 cycles, then release -> REQ_READY=0 during reset and 1 after the first edge; RSP_VALID=0 throughout.
- Store then load: store 0xDEADBEEF at 0x0000_0010, with RSP_READY=1 -> RSP_VALID at edge k+3, RSP_RDATA=0, RSP_ERR=0. Then load 0x10 -> RSP_RDATA=0xDEADBEEF.
- Misaligned and out-of-range, DEPTH_WORDS=1024:
  - store to 0x13 -> RSP_ERR=1; a following load of 0x10 still returns 0xDEADBEEF;
  - load of 0x0000_1000 -> RSP_ERR=1, RSP_RDATA=0.
- Back-pressure: load with RSP_READY=0 for 5 cycles -> RSP_VALID, RSP_RDATA and RSP_ERR stable and REQ_READY=0 for all 5; handshake on cycle 6, then REQ_READY=1 the next cycle.
- LATENCY=0 build: REQ_VALID held high for 10 cycles with RSP_READY=1 -> acceptances every 3 cycles (4 total), each RSP_VALID one edge after acceptance.
- Reset mid-WAIT: store 0x12345678 to 0x20, then assert RESET_N=0 during WAIT -> outputs clear immediately; after release, a load of 0x20 does not return 0x12345678 (address 0x20 is first pre-written with 0xAAAA5555, which it must still return).
